// File: rtl/main_ram_arbiter.sv
// main_ram_arbiter
//   Shares one single-port main RAM (1-cycle read latency, write-first)
//   between two requesters. Every access runs IDLE -> CMD -> WAIT -> RESP,
//   so the best case is one access per four clocks. The RAM command is
//   driven from registers. Read data comes back with a one-cycle ack pulse
//   to the granted port only.
//
// Optional build macro:
//   MAIN_RAM_ARB_FIXED_PRIO_EN - when defined, port 0 always wins
//   simultaneous requests. Otherwise the ports alternate round-robin.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN/weN/addrN/wdataN/bytyselN
//                            requester N command, held stable until ackN
//   ackN, rdataN             completion pulse and read data (valid with ackN)
//   ram_addr/ram_wrdata/ram_wrbytesel/ram_write
//                            registered RAM command
//   ram_rddata               RAM read data, one cycle after address sampling
module main_ram_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0,
  input  logic                    we0,
  input  logic [ADDR_WIDTH-1:0]   addr0,
  input  logic [DATA_WIDTH-1:0]   wdata0,
  input  logic [DATA_WIDTH/8-1:0] bytesel0,
  output logic                    ack0,
  output logic [DATA_WIDTH-1:0]   rdata0,
  input  logic                    req1,
  input  logic                    we1,
  input  logic [ADDR_WIDTH-1:0]   addr1,
  input  logic [DATA_WIDTH-1:0]   wdata1,
  input  logic [DATA_WIDTH/8-1:0] bytesel1,
  output logic                    ack1,
  output logic [DATA_WIDTH-1:0]   rdata1,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wrdata,
  output logic [DATA_WIDTH/8-1:0] ram_wrbytesel,
  output logic                    ram_write,
  input  logic [DATA_WIDTH-1:0]   ram_rddata
);

  localparam int BW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                  state_q,   state_d;
  logic                    grant_q,   grant_d;   // 0 = port 0, 1 = port 1
  logic                    ack0_q,    ack0_d;
  logic                    ack1_q,    ack1_d;
  logic [DATA_WIDTH-1:0]   rdata0_q,  rdata0_d;
  logic [DATA_WIDTH-1:0]   rdata1_q,  rdata1_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]   ram_wrdata_q, ram_wrdata_d;
  logic [BW-1:0]           ram_bsel_q, ram_bsel_d;
  logic                    ram_write_q, ram_write_d;
  logic                    win;                  // winner of this IDLE cycle
`ifndef MAIN_RAM_ARB_FIXED_PRIO_EN
  logic                    last_grant_q, last_grant_d;
`endif

  // Winner selection: a lone request always wins; on contention either
  // port 0 (fixed priority) or the port that did not win last time.
`ifdef MAIN_RAM_ARB_FIXED_PRIO_EN
  assign win = ~req0;
`else
  assign win = (req0 && req1) ? ~last_grant_q : req1;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ack0_d       = ack0_q;
    ack1_d       = ack1_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    ram_addr_d   = ram_addr_q;
    ram_wrdata_d = ram_wrdata_q;
    ram_bsel_d   = ram_bsel_q;
    ram_write_d  = ram_write_q;
`ifndef MAIN_RAM_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          grant_d      = win;
`ifndef MAIN_RAM_ARB_FIXED_PRIO_EN
          last_grant_d = win;
`endif
          ram_addr_d   = win ? addr1    : addr0;
          ram_wrdata_d = win ? wdata1   : wdata0;
          ram_bsel_d   = win ? bytesel1 : bytesel0;
          ram_write_d  = win ? we1      : we0;
          state_d      = S_CMD;
        end
      end
      // RAM samples the command at the end of this cycle.
      S_CMD: begin
        ram_write_d = 1'b0;
        state_d     = S_WAIT;
      end
      // RAM output is valid now; capture it for the granted port only.
      S_WAIT: begin
        if (grant_q) begin
          rdata1_d = ram_rddata;
          ack1_d   = 1'b1;
        end else begin
          rdata0_d = ram_rddata;
          ack0_d   = 1'b1;
        end
        state_d = S_RESP;
      end
      // The acked requester still shows its old req here, so requests
      // are deliberately not looked at in this state.
      S_RESP: begin
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      ram_addr_q   <= '0;
      ram_wrdata_q <= '0;
      ram_bsel_q   <= '0;
      ram_write_q  <= 1'b0;
`ifndef MAIN_RAM_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;  // port 0 wins the first contention
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      ram_addr_q   <= ram_addr_d;
      ram_wrdata_q <= ram_wrdata_d;
      ram_bsel_q   <= ram_bsel_d;
      ram_write_q  <= ram_write_d;
`ifndef MAIN_RAM_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign ack0          = ack0_q;
  assign ack1          = ack1_q;
  assign rdata0        = rdata0_q;
  assign rdata1        = rdata1_q;
  assign ram_addr      = ram_addr_q;
  assign ram_wrdata    = ram_wrdata_q;
  assign ram_wrbytesel = ram_bsel_q;
  assign ram_write     = ram_write_q;

endmodule

// File: tb/tb_main_ram_arbiter.sv
// Directed bench for main_ram_arbiter with a write-first RAM model.
module tb_main_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [14:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [3:0]  bytesel0, bytesel1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic [14:0] ram_addr;
  logic [31:0] ram_wrdata;
  logic [3:0]  ram_wrbytesel;
  logic        ram_write;
  logic [31:0] ram_rddata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:32767];

  always #5 clk = ~clk;

  main_ram_arbiter #(.ADDR_WIDTH(15), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .bytesel0(bytesel0),
    .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .bytesel1(bytesel1),
    .ack1(ack1), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_wrdata(ram_wrdata), .ram_wrbytesel(ram_wrbytesel),
    .ram_write(ram_write), .ram_rddata(ram_rddata)
  );

  // Write-first single-port RAM, one cycle read latency.
  always @(posedge clk) begin : ram_model
    logic [31:0] w;
    w = mem[ram_addr];
    if (ram_write) begin
      for (int b = 0; b < 4; b++)
        if (ram_wrbytesel[b]) w[b*8 +: 8] = ram_wrdata[b*8 +: 8];
      mem[ram_addr] <= w;
    end
    ram_rddata <= w;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one access on a single port starting from IDLE; checks command,
  // latency (ack in 3rd cycle), data and that the other port stays quiet.
  task automatic do_access(input bit port, input bit we, input logic [14:0] a,
                           input logic [31:0] wd, input logic [3:0] bs,
                           input logic [31:0] exp_rd, input string tag);
    int n;
    bit got;
    if (port) begin req1 = 1; we1 = we; addr1 = a; wdata1 = wd; bytesel1 = bs; end
    else      begin req0 = 1; we0 = we; addr0 = a; wdata0 = wd; bytesel0 = bs; end
    n = 0; got = 0;
    while (!got && n < 10) begin
      @(negedge clk); n++;
      if (n == 1) begin
        chk({tag, "_ram_write_cmd"}, {31'd0, ram_write}, {31'd0, we});
        chk({tag, "_ram_addr"}, {17'd0, ram_addr}, {17'd0, a});
      end
      got = port ? ack1 : ack0;
    end
    chk({tag, "_latency"}, n, 3);
    chk({tag, "_rdata"}, port ? rdata1 : rdata0, exp_rd);
    chk({tag, "_other_ack"}, {31'd0, port ? ack0 : ack1}, 32'd0);
    if (port) req1 = 0; else req0 = 0;
    @(negedge clk);
    chk({tag, "_ack_drop"}, {31'd0, port ? ack1 : ack0}, 32'd0);
  endtask

  initial begin
    int n, k, cnt0, cnt1, last_n;
    bit port;
    for (int i = 0; i < 32768; i++) mem[i] = 32'h0;
    mem[0] = 32'h1111_0000;
    mem[1] = 32'h2222_0001;
    rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; bytesel0 = 0; bytesel1 = 0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ack0", {31'd0, ack0}, 0);
    chk("rst_ack1", {31'd0, ack1}, 0);
    chk("rst_ram_write", {31'd0, ram_write}, 0);
    chk("rst_ram_addr", {17'd0, ram_addr}, 0);
    chk("rst_ram_wrdata", ram_wrdata, 0);
    chk("rst_ram_bsel", {28'd0, ram_wrbytesel}, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    rst = 0;
    @(negedge clk);

    // 1. Port 0 full write then read back
    do_access(0, 1, 15'h0010, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, "t1_wr");
    do_access(0, 0, 15'h0010, 32'h0, 4'hF, 32'hDEADBEEF, "t1_rd");

    // 2. Port 1 byte-lane write then read
    do_access(1, 1, 15'h0010, 32'h0000AA00, 4'b0010, 32'hDEADAAEF, "t2_wr");
    do_access(1, 0, 15'h0010, 32'h0, 4'hF, 32'hDEADAAEF, "t2_rd");
    chk("t2_rdata0_kept", rdata0, 32'hDEADBEEF);

    // 3. Both requesting continuously: 8 acks
    req0 = 1; we0 = 0; addr0 = 15'h0000;
    req1 = 1; we1 = 0; addr1 = 15'h0001;
    cnt0 = 0; cnt1 = 0;
    for (k = 0; k < 8; k++) begin
      n = 0;
      do begin
        @(negedge clk); n++;
        chk("t3_ack_exclusive", {31'd0, ack0 & ack1}, 0);
      end while (!(ack0 || ack1) && n < 10);
      port = ack1;
      if (ack1) cnt1++; else if (ack0) cnt0++;
      chk("t3_interval", n, (k == 0) ? 3 : 4);
`ifdef MAIN_RAM_ARB_FIXED_PRIO_EN
      chk("t3_winner", {31'd0, port}, 0);
`else
      chk("t3_winner", {31'd0, port}, k % 2);
`endif
      chk("t3_rdata", port ? rdata1 : rdata0, port ? 32'h2222_0001 : 32'h1111_0000);
    end
    req0 = 0; req1 = 0;
`ifdef MAIN_RAM_ARB_FIXED_PRIO_EN
    chk("t3_cnt0", cnt0, 8);
    chk("t3_cnt1", cnt1, 0);
`else
    chk("t3_cnt0", cnt0, 4);
    chk("t3_cnt1", cnt1, 4);
`endif
    repeat (2) @(negedge clk);

    // 4. Reset during WAIT of a port 1 read
    req1 = 1; we1 = 0; addr1 = 15'h0010;
    @(negedge clk);  // CMD
    @(negedge clk);  // WAIT
    rst = 1;
    @(negedge clk);
    chk("t4_ack1", {31'd0, ack1}, 0);
    chk("t4_ram_write", {31'd0, ram_write}, 0);
    chk("t4_rdata1", rdata1, 0);
    chk("t4_ram_addr", {17'd0, ram_addr}, 0);
    rst = 0; req1 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_no_ack1", {31'd0, ack1}, 0);
    end
    do_access(0, 0, 15'h0010, 32'h0, 4'hF, 32'hDEADAAEF, "t4_rd0");

    // 5. req0 held over back-to-back reads, command changed on ack
    req0 = 1; we0 = 0; addr0 = 15'h0000;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack0 && n < 10);
    chk("t5_lat1", n, 3);
    chk("t5_rd1", rdata0, 32'h1111_0000);
    addr0 = 15'h0001;
    last_n = 0;
    do begin @(negedge clk); last_n++; end while (!ack0 && last_n < 10);
    chk("t5_gap", last_n, 4);
    chk("t5_rd2", rdata0, 32'h2222_0001);
    req0 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_dup", {31'd0, ack0}, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
